// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default operand width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package serial_add_ctrl_pkg;

  // Operand/result width used when the instantiating code does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. Encoding 2'b11 is unused and is steered back to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two half adders plus an OR of their carries.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs continuously.

// Half adder: sum is the XOR of the inputs, carry is their AND.
module serial_half_add (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule : serial_half_add

module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s1;
  logic c1;
  logic c2;

  // First stage adds the two operand bits.
  serial_half_add u_ha_ab (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  // Second stage folds in the running carry.
  serial_half_add u_ha_c (
    .a_i (s1),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c2)
  );

  // At most one of the two stage carries can be set, so OR gives the majority.
  assign c_o = c1 | c2;

endmodule : serial_fa_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: captures A, B, cin on accept, adds LSB-first through one shared full-add cell.
// Latency: out_valid rises the cycle after edge k+WIDTH (k = accepting edge); accepts spaced >= WIDTH+2.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so new operands wait.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready
);

  // Counter only needs to reach WIDTH-1; the run exits on that value, so it never wraps.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             c_q,     c_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             carry_q, carry_d;

  logic             accept;
  logic             last_bit;
  logic             fa_a;
  logic             fa_b;
  logic             fa_s;
  logic             fa_co;

  // Handshake and end-of-run decodes shared by the FSM and the datapath.
  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  // The single full-add cell always looks at the bit selected by the counter.
  assign fa_a = a_q[cnt_q];
  assign fa_b = b_q[cnt_q];

  serial_fa_cell u_fa (
    .a_i (fa_a),
    .b_i (fa_b),
    .c_i (c_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  // State register; reset forces IDLE regardless of any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept -> RUN, last bit -> DONE, consumer take -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        // Illegal encoding recovers to a clean idle.
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath next-state: capture on accept, one sum bit and carry step per RUN edge.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Operands are frozen here so later input changes cannot disturb the run.
          a_d   = inp1;
          b_d   = inp2;
          c_d   = cin;
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        sum_d[cnt_q] = fa_s;
        c_d          = fa_co;
        if (last_bit) begin
          // Final carry is published together with the last sum bit.
          carry_d = fa_co;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        // DONE and the illegal encoding leave the datapath untouched.
        a_d = a_q;
      end
    endcase
  end

  // Datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 against an arithmetic reference.
// Drives and samples on the falling edge, away from the active rising edge.
// Covers reset, directed vectors, output hold, ignored inputs, mid-run reset and random traffic.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] inp1;
  logic [W-1:0] inp2;
  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         out_valid;
  logic         out_ready;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp1      (inp1),
    .inp2      (inp2),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction from the current falling edge. Reference: plain (W+1)-bit addition.
  // inject: keep in_valid high with 0x01+0x01 during RUN/DONE, which must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int hold, input bit inject, input bit rnd_rdy);
    logic [W:0]   exp;
    logic [W-1:0] held_sum;
    logic         held_carry;
    int           n;
    int           guard;
    bit           early_valid;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    inp1 = a; inp2 = b; cin = ci; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);  // accepting edge k
    @(negedge clk);
    if (inject) begin
      inp1 = 8'h01; inp2 = 8'h01; cin = 1'b0; in_valid = 1'b1;
    end else begin
      inp1 = W'($urandom); inp2 = W'($urandom); cin = 1'($urandom); in_valid = 1'b0;
    end
    chk("run_not_ready", {31'd0, in_ready}, 32'd0);
    n = 0;
    early_valid = 1'b0;
    while (n < 40) begin
      if (out_valid) break;
      if (rnd_rdy) out_ready = 1'($urandom);
      @(posedge clk); @(negedge clk); n++;
    end
    chk("latency", n, W);
    in_valid = 1'b0;
    chk("sum", {24'd0, sum}, {24'd0, exp[W-1:0]});
    chk("carry", {31'd0, carry}, {31'd0, exp[W]});
    held_sum = sum; held_carry = carry;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      if (!out_valid || sum !== held_sum || carry !== held_carry) early_valid = 1'b1;
    end
    chk("hold_stable", {31'd0, early_valid}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("back_idle_nvalid", {31'd0, out_valid}, 32'd0);
    chk("idle_sum_kept", {24'd0, sum}, {24'd0, exp[W-1:0]});
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; inp1 = '0; inp2 = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);

    // Reset wins over an accept on the same edge.
    in_valid = 1'b1; inp1 = 8'h11; inp2 = 8'h22;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_beats_accept", {31'd0, in_ready}, 32'd1);

    // Directed vectors.
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h5A, 8'hA5, 1'b1, 0, 1'b0, 1'b0);
    run_op(8'h12, 8'h34, 1'b0, 0, 1'b0, 1'b0);
    // Held result for 5 cycles of out_ready=0.
    run_op(8'hC3, 8'h7E, 1'b1, 5, 1'b0, 1'b0);
    // New operands with in_valid during RUN are ignored.
    run_op(8'hA0, 8'h0B, 1'b0, 2, 1'b1, 1'b0);

    // Reset at edge k+4 aborts the operation.
    inp1 = 8'h77; inp2 = 8'h66; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);  // edge k
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);  // edge k+4
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_sum_clr", {24'd0, sum}, 32'd0);
    chk("abort_carry_clr", {31'd0, carry}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);
    out_ready = 1'b0;
    run_op(8'h03, 8'h04, 1'b0, 0, 1'b0, 1'b0);

    // Random back-to-back traffic with random consumer readiness.
    for (int t = 0; t < 30; t++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3),
             1'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits (legal values 2..32).
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit, with a synchronous, active-low reset.
REQ-004 Port inp1 SHALL be an input, WIDTH bits: operand A.
REQ-005 Port inp2 SHALL be an input, WIDTH bits: operand B.
REQ-006 Port cin SHALL be an input, 1 bit: carry-in.
REQ-007 Port in_valid SHALL be an input, 1 bit: operands are presented.
REQ-008 Port in_ready SHALL be an output, 1 bit: the block accepts operands this cycle.
REQ-009 Port sum SHALL be an output, WIDTH bits: the result A+B+cin, modulo 2^WIDTH.
REQ-010 Port carry SHALL be an output, 1 bit: the carry-out of bit WIDTH-1.
REQ-011 Port out_valid SHALL be an output, 1 bit: sum and carry are valid.
REQ-012 Port out_ready SHALL be an input, 1 bit: the consumer takes the result.

Function
REQ-013 The block SHALL compute the sum bit-serially, LSB first, using exactly one 1-bit full-add cell shared across all bit positions.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be Moore outputs.
REQ-016 The IDLE->RUN transition SHALL occur on the edge where in_valid&&in_ready, which is the accepting edge k.
REQ-017 On edge k: inp1, inp2 and cin SHALL be captured into internal registers, and the bit counter SHALL be cleared to 0.
REQ-018 In RUN, each edge SHALL process bit cnt:
- sum_reg[cnt] <= a[cnt]^b[cnt]^c
- c <= majority(a[cnt],b[cnt],c)
- cnt <= cnt+1
REQ-019 RUN SHALL last exactly WIDTH edges (k+1..k+WIDTH). On edge k+WIDTH, processing bit WIDTH-1, the state SHALL become DONE and carry SHALL take the final c.
REQ-020 Latency: out_valid SHALL first be high in the cycle after edge k+WIDTH. Minimum spacing between accepts SHALL be WIDTH+2 cycles.
REQ-021 In DONE, sum and carry SHALL be held stable for as long as out_ready=0, for any number of cycles.
REQ-022 DONE->IDLE SHALL occur on the edge where out_ready=1. sum and carry SHALL keep their last values in IDLE and RUN until overwritten.
REQ-023 in_valid in RUN or DONE SHALL be ignored: no capture and no effect on the computation in flight.
REQ-024 Changes on inp1, inp2 or cin after edge k SHALL NOT affect the result.
REQ-025 out_ready in IDLE or RUN SHALL be ignored.
REQ-026 Counter width SHALL be clog2(WIDTH). There SHALL be no wrap beyond WIDTH-1, because the exit from RUN is decoded at cnt==WIDTH-1.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL set:
- state=IDLE
- cnt=0
- c=0
- sum=0
- carry=0
- out_valid=0
- in_ready=1 (from the next cycle)
REQ-028 Reset SHALL override all other inputs, including an accept or out_ready on the same edge.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation with no result ever signalled. The first accept after reset SHALL behave as a fresh start.

Structure
REQ-030 A shared constants header SHALL hold:
- the state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10
- the default WIDTH
REQ-031 The unused encoding 2'b11 SHALL return to IDLE.
REQ-032 The 1-bit cell SHALL be a separate sub-module serial_fa_cell, built from two half-adder instances plus an OR of their carries. It SHALL be purely combinational.
REQ-033 All sequential logic SHALL reside in serial_add_ctrl.

Verification (WIDTH=8)
REQ-034 Stimulus: inp1=0xFF, inp2=0x01, cin=0, accepted at edge k. Required response: out_valid=1 after edge k+8, sum=0x00, carry=1.
REQ-035 Stimulus: inp1=0x5A, inp2=0xA5, cin=1. Required response: sum=0x00, carry=1. Then 0x12+0x34, cin=0: sum=0x46, carry=0.
REQ-036 Stimulus: hold out_ready=0 for 5 cycles in DONE. Required response: out_valid stays 1 and sum/carry are unchanged. On out_ready=1, IDLE and in_ready=1 on the next cycle.
REQ-037 Stimulus: in_valid=1 with new operands 0x01+0x01 during RUN. Required response: ignored, and the original result is delivered.
REQ-038 Stimulus: rst_n=0 at edge k+4 of an operation. Required response: out_valid never rises for it, and in_ready=1 the cycle after reset. A following 0x03+0x04 gives sum=0x07, carry=0.
REQ-039 Stimulus: random back-to-back operands with random out_ready. Required response: every result equals the reference A+B+cin, and the accept-to-out_valid latency is exactly 8 edges.
